// File: rtl/instruction_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// instruction_sequencer_pkg
// Shared definitions for the instruction sequencer:
//   - FSM state encoding
//   - processor opcode constants and opcode field width
//   - state classification helpers
// The opcode occupies the top OPC_W bits of an instruction word
// (DIN[BITS-1:BITS-3]).
// -----------------------------------------------------------------------------
package instruction_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_WAIT_MEM  = 3'd2,
        S_ISSUE     = 3'd3,
        S_WAIT_DONE = 3'd4,
        S_FINISH    = 3'd5,
        S_HALT      = 3'd6,
        S_ERROR     = 3'd7
    } state_t;

    localparam int OPC_W = 3;

    localparam logic [OPC_W-1:0] OP_MV   = 3'b000;
    localparam logic [OPC_W-1:0] OP_MVI  = 3'b001;
    localparam logic [OPC_W-1:0] OP_ADD  = 3'b010;
    localparam logic [OPC_W-1:0] OP_SUB  = 3'b011;
    localparam logic [OPC_W-1:0] OP_HALT = 3'b111;

    // States from which a Start request is accepted.
    function automatic logic is_startable(input state_t s);
        return (s == S_IDLE) || (s == S_FINISH) || (s == S_HALT) || (s == S_ERROR);
    endfunction

endpackage

// File: rtl/instruction_sequencer_done_watchdog.sv
// -----------------------------------------------------------------------------
// done_watchdog
// Cycle counter used to bound the wait for the processor's Done.
// Ports:
//   clk_i      clock, rising edge
//   rst_ni     asynchronous active-low reset (counter -> 0)
//   clr_i      synchronous clear (priority over enable)
//   en_i       count one cycle
//   expired_o  the count reaches TIMEOUT with this cycle's increment
// The counter saturates so it can never wrap back below the limit.
// -----------------------------------------------------------------------------
module done_watchdog #(
    parameter int TIMEOUT = 15
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W:0]   LIMIT   = (CNT_W+1)'(TIMEOUT);
    localparam logic [CNT_W:0]   ONE     = (CNT_W+1)'(1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W:0]   cnt_next_d;

    assign cnt_next_d = {1'b0, cnt_q} + ONE;
    assign expired_o  = (cnt_next_d >= LIMIT);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i && (cnt_q != CNT_MAX)) begin
            cnt_q <= cnt_next_d[CNT_W-1:0];
        end
    end

endmodule

// File: rtl/instruction_sequencer.sv
// -----------------------------------------------------------------------------
// instruction_sequencer
// Fetch/issue controller that runs a program from a synchronous instruction
// memory on simple_processor: fetch word at PC, drive it on DIN, pulse Run,
// wait for Done (bounded by a watchdog), advance.
// Ports:
//   Clock, Resetn          clock / asynchronous active-low reset
//   Start, Stop            run request (level) / abort at instruction boundary
//   ProgLen                number of words to execute, sampled on Start
//   MemAddr, MemEn         memory read request (data valid next cycle)
//   MemData                memory read data
//   DIN, Run, Done         processor instruction, issue pulse, completion
//   PC                     current instruction index
//   Busy                   fetch/issue activity in progress
//   Finished/Halted/Error  sticky terminal status flags
// -----------------------------------------------------------------------------
module instruction_sequencer
    import instruction_sequencer_pkg::*;
#(
    parameter int               BITS    = 16,
    parameter int               ADDR_W  = 5,
    parameter int               TIMEOUT = 15,
    parameter logic [OPC_W-1:0] HALT_OP = OP_HALT
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              Start,
    input  logic              Stop,
    input  logic [ADDR_W:0]   ProgLen,
    output logic [ADDR_W-1:0] MemAddr,
    output logic              MemEn,
    input  logic [BITS-1:0]   MemData,
    output logic [BITS-1:0]   DIN,
    output logic              Run,
    input  logic              Done,
    output logic [ADDR_W:0]   PC,
    output logic              Busy,
    output logic              Finished,
    output logic              Halted,
    output logic              Error
);

    localparam logic [ADDR_W:0] PC_ONE = (ADDR_W+1)'(1);

    state_t            state_q;
    logic [ADDR_W:0]   pc_q;
    logic [ADDR_W:0]   len_q;
    logic [BITS-1:0]   din_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              mem_en_q;
    logic              run_q;
    logic              busy_q;
    logic              finished_q;
    logic              halted_q;
    logic              error_q;
    logic              stop_q;

    logic [ADDR_W:0]   pc_d;
    logic [OPC_W-1:0]  opcode_w;
    logic              stop_seen_w;
    logic              wd_clr_w;
    logic              wd_en_w;
    logic              wd_expired_w;

    assign pc_d        = pc_q + PC_ONE;
    assign opcode_w    = MemData[BITS-1 -: OPC_W];
    // A Stop arriving this cycle counts as pending immediately.
    assign stop_seen_w = stop_q | Stop;

    // Watchdog is cleared while the word is in flight from memory, so it
    // reads 0 during ISSUE and counts cycles since Run from there on.
    assign wd_clr_w = (state_q == S_WAIT_MEM);
    assign wd_en_w  = (state_q == S_ISSUE) || (state_q == S_WAIT_DONE);

    done_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_done_watchdog (
        .clk_i     (Clock),
        .rst_ni    (Resetn),
        .clr_i     (wd_clr_w),
        .en_i      (wd_en_w),
        .expired_o (wd_expired_w)
    );

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q    <= S_IDLE;
            pc_q       <= '0;
            len_q      <= '0;
            din_q      <= '0;
            mem_addr_q <= '0;
            mem_en_q   <= 1'b0;
            run_q      <= 1'b0;
            busy_q     <= 1'b0;
            finished_q <= 1'b0;
            halted_q   <= 1'b0;
            error_q    <= 1'b0;
            stop_q     <= 1'b0;
        end else begin
            // MemEn and Run are single-cycle strobes tied to state entry.
            mem_en_q <= 1'b0;
            run_q    <= 1'b0;
            case (state_q)
                S_IDLE, S_FINISH, S_HALT, S_ERROR: begin
                    if (Start && is_startable(state_q)) begin
                        len_q      <= ProgLen;
                        pc_q       <= '0;
                        finished_q <= 1'b0;
                        halted_q   <= 1'b0;
                        error_q    <= 1'b0;
                        stop_q     <= 1'b0;
                        if (ProgLen == '0) begin
                            state_q    <= S_FINISH;
                            finished_q <= 1'b1;
                            busy_q     <= 1'b0;
                        end else begin
                            state_q    <= S_FETCH;
                            mem_en_q   <= 1'b1;
                            mem_addr_q <= '0;
                            busy_q     <= 1'b1;
                        end
                    end
                end
                S_FETCH: begin
                    stop_q  <= stop_seen_w;
                    state_q <= S_WAIT_MEM;
                end
                S_WAIT_MEM: begin
                    // A halt opcode or pending Stop ends the run before issue;
                    // DIN keeps the previous instruction.
                    if ((opcode_w == HALT_OP) || stop_seen_w) begin
                        state_q  <= S_HALT;
                        halted_q <= 1'b1;
                        busy_q   <= 1'b0;
                        stop_q   <= 1'b0;
                    end else begin
                        din_q   <= MemData;
                        run_q   <= 1'b1;
                        stop_q  <= stop_seen_w;
                        state_q <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    stop_q  <= stop_seen_w;
                    state_q <= S_WAIT_DONE;
                end
                S_WAIT_DONE: begin
                    // Done wins over an expiry in the same cycle.
                    if (Done) begin
                        pc_q <= pc_d;
                        if (pc_d == len_q) begin
                            state_q    <= S_FINISH;
                            finished_q <= 1'b1;
                            busy_q     <= 1'b0;
                            stop_q     <= 1'b0;
                        end else if (stop_seen_w) begin
                            state_q  <= S_HALT;
                            halted_q <= 1'b1;
                            busy_q   <= 1'b0;
                            stop_q   <= 1'b0;
                        end else begin
                            state_q    <= S_FETCH;
                            mem_en_q   <= 1'b1;
                            mem_addr_q <= pc_d[ADDR_W-1:0];
                        end
                    end else if (wd_expired_w) begin
                        state_q <= S_ERROR;
                        error_q <= 1'b1;
                        busy_q  <= 1'b0;
                        stop_q  <= 1'b0;
                    end else begin
                        stop_q <= stop_seen_w;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign MemAddr  = mem_addr_q;
    assign MemEn    = mem_en_q;
    assign DIN      = din_q;
    assign Run      = run_q;
    assign PC       = pc_q;
    assign Busy     = busy_q;
    assign Finished = finished_q;
    assign Halted   = halted_q;
    assign Error    = error_q;

endmodule

// File: tb/tb_instruction_sequencer.sv
// -----------------------------------------------------------------------------
// tb_instruction_sequencer
// Directed bench for instruction_sequencer with a synchronous memory model and
// a processor model that raises Done a programmable number of cycles after Run.
// -----------------------------------------------------------------------------
module tb_instruction_sequencer;

    logic        Clock = 1'b0;
    logic        Resetn;
    logic        Start;
    logic        Stop;
    logic [5:0]  ProgLen;
    logic [4:0]  MemAddr;
    logic        MemEn;
    logic [15:0] MemData = 16'd0;
    logic [15:0] DIN;
    logic        Run;
    logic        Done;
    logic [5:0]  PC;
    logic        Busy;
    logic        Finished;
    logic        Halted;
    logic        Error;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [15:0] mem [0:31];
    int done_lat = 2;
    int dcnt = 0;
    int cyc = 0;

    // Monitor state
    int          run_cnt = 0;
    int          memen_cnt = 0;
    int          run_cyc [0:255];
    logic [15:0] run_din [0:255];
    int          memen_cyc [0:255];
    logic [4:0]  last_addr = 5'd0;
    logic        err_prev = 1'b0;
    int          err_rise = 0;

    instruction_sequencer dut (
        .Clock    (Clock),
        .Resetn   (Resetn),
        .Start    (Start),
        .Stop     (Stop),
        .ProgLen  (ProgLen),
        .MemAddr  (MemAddr),
        .MemEn    (MemEn),
        .MemData  (MemData),
        .DIN      (DIN),
        .Run      (Run),
        .Done     (Done),
        .PC       (PC),
        .Busy     (Busy),
        .Finished (Finished),
        .Halted   (Halted),
        .Error    (Error)
    );

    always #5 Clock = ~Clock;

    always @(posedge Clock) cyc <= cyc + 1;

    always @(posedge Clock) begin
        if (MemEn) MemData <= mem[MemAddr];
    end

    always @(posedge Clock or negedge Resetn) begin
        if (!Resetn) dcnt <= 0;
        else if (Run) dcnt <= 1;
        else if (dcnt != 0) begin
            if (dcnt == done_lat) dcnt <= 0;
            else if (dcnt < 1000) dcnt <= dcnt + 1;
        end
    end

    assign Done = (done_lat != 0) && (dcnt == done_lat);

    always @(negedge Clock) begin
        if (Run) begin
            if (run_cnt < 256) begin
                run_cyc[run_cnt] <= cyc;
                run_din[run_cnt] <= DIN;
            end
            run_cnt <= run_cnt + 1;
        end
        if (MemEn) begin
            if (memen_cnt < 256) memen_cyc[memen_cnt] <= cyc;
            memen_cnt <= memen_cnt + 1;
            last_addr <= MemAddr;
        end
        err_prev <= Error;
        if (Error && !err_prev) err_rise <= cyc;
    end

    // Called at a negedge; leaves at the following negedge.
    task automatic pulse_start(input logic [5:0] len, input logic stp);
        Start   = 1'b1;
        Stop    = stp;
        ProgLen = len;
        @(negedge Clock);
        Start = 1'b0;
        Stop  = 1'b0;
    endtask

    task automatic wait_terminal(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge Clock);
            if (!Busy && (Finished || Halted || Error)) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (2) @(negedge Clock);
    endtask

    task automatic wait_runs(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge Clock);
            if (run_cnt >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic load_basic();
        for (int i = 0; i < 32; i++) mem[i] = 16'd0;
        mem[0] = 16'b001_001_000_0001111;
        mem[1] = 16'b000_001_011_0000000;
        mem[2] = 16'b010_001_011_0000000;
        mem[3] = 16'b011_001_011_0000000;
    endtask

    task automatic test_reset();
        logic [32:0] snap;
        Resetn = 1'b0;
        repeat (3) @(negedge Clock);
        snap = {PC, DIN, Run, MemEn, MemAddr, Busy, Finished, Halted, Error};
        n_cmp++;
        if (snap !== 33'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h want 0", snap);
        end
        Resetn = 1'b1;
        repeat (2) @(negedge Clock);
        n_cmp++;
        if (Busy !== 1'b0 || MemEn !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: Busy=%b MemEn=%b want 0 0", Busy, MemEn);
        end
    endtask

    task automatic test_basic();
        int rb, mb;
        bit ok;
        load_basic();
        done_lat = 2;
        rb = run_cnt;
        mb = memen_cnt;
        pulse_start(6'd4, 1'b0);
        wait_runs(rb + 1, 50, ok);
        // Start while busy must be ignored.
        pulse_start(6'd1, 1'b0);
        wait_terminal(200, ok);
        n_cmp++;
        if (!ok) begin n_fail++; $display("FAIL basic_terminal: no terminal state within budget"); end
        n_cmp++;
        if (run_cnt - rb !== 4) begin n_fail++; $display("FAIL basic_runs: got %0d want 4", run_cnt - rb); end
        for (int i = 1; i < 4; i++) begin
            n_cmp++;
            if (run_cyc[rb+i] - run_cyc[rb+i-1] !== 5) begin
                n_fail++;
                $display("FAIL basic_gap%0d: got %0d want 5", i, run_cyc[rb+i] - run_cyc[rb+i-1]);
            end
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (run_din[rb+i] !== mem[i]) begin
                n_fail++;
                $display("FAIL basic_din%0d: got %h want %h", i, run_din[rb+i], mem[i]);
            end
        end
        n_cmp++;
        if (run_cyc[rb] - memen_cyc[mb] !== 2) begin
            n_fail++;
            $display("FAIL basic_fetch_latency: got %0d want 2", run_cyc[rb] - memen_cyc[mb]);
        end
        n_cmp++;
        if ({Finished, Halted, Error, Busy} !== 4'b1000) begin
            n_fail++;
            $display("FAIL basic_flags: F/H/E/B got %b want 1000", {Finished, Halted, Error, Busy});
        end
        n_cmp++;
        if (PC !== 6'd4) begin n_fail++; $display("FAIL basic_pc: got %0d want 4", PC); end
    endtask

    task automatic test_halt_op();
        int rb, mb;
        bit ok;
        for (int i = 0; i < 32; i++) mem[i] = 16'd0;
        mem[0] = 16'b001_000_000_0000101;
        mem[1] = 16'b010_000_001_0000000;
        mem[2] = 16'b111_0000000000000;
        mem[3] = 16'b011_000_001_0000000;
        mem[4] = 16'b000_001_000_0000000;
        done_lat = 2;
        rb = run_cnt;
        mb = memen_cnt;
        pulse_start(6'd5, 1'b0);
        wait_terminal(200, ok);
        n_cmp++;
        if (!ok) begin n_fail++; $display("FAIL halt_terminal: no terminal state within budget"); end
        n_cmp++;
        if (run_cnt - rb !== 2) begin n_fail++; $display("FAIL halt_runs: got %0d want 2", run_cnt - rb); end
        n_cmp++;
        if (memen_cnt - mb !== 3) begin n_fail++; $display("FAIL halt_fetches: got %0d want 3", memen_cnt - mb); end
        n_cmp++;
        if ({Finished, Halted, Error, Busy} !== 4'b0100) begin
            n_fail++;
            $display("FAIL halt_flags: F/H/E/B got %b want 0100", {Finished, Halted, Error, Busy});
        end
        n_cmp++;
        if (PC !== 6'd2) begin n_fail++; $display("FAIL halt_pc: got %0d want 2", PC); end
        n_cmp++;
        if (DIN !== 16'b010_000_001_0000000) begin n_fail++; $display("FAIL halt_din: got %h want %h", DIN, 16'b010_000_001_0000000); end
    endtask

    task automatic test_timeout();
        int rb;
        bit ok;
        load_basic();
        done_lat = 0;
        rb = run_cnt;
        pulse_start(6'd4, 1'b0);
        wait_terminal(100, ok);
        n_cmp++;
        if (!ok) begin n_fail++; $display("FAIL timeout_terminal: no terminal state within budget"); end
        n_cmp++;
        if (run_cnt - rb !== 1) begin n_fail++; $display("FAIL timeout_runs: got %0d want 1", run_cnt - rb); end
        n_cmp++;
        if (err_rise - run_cyc[rb] !== 15) begin
            n_fail++;
            $display("FAIL timeout_latency: got %0d want 15", err_rise - run_cyc[rb]);
        end
        n_cmp++;
        if ({Finished, Halted, Error, Busy} !== 4'b0010) begin
            n_fail++;
            $display("FAIL timeout_flags: F/H/E/B got %b want 0010", {Finished, Halted, Error, Busy});
        end
        n_cmp++;
        if (PC !== 6'd0) begin n_fail++; $display("FAIL timeout_pc: got %0d want 0", PC); end
    endtask

    task automatic test_done_at_limit();
        int rb;
        bit ok;
        load_basic();
        // Done on the 14th cycle after Run coincides with the expiry cycle.
        done_lat = 14;
        pulse_start(6'd1, 1'b0);
        wait_terminal(100, ok);
        n_cmp++;
        if ({Finished, Error, PC} !== {2'b10, 6'd1}) begin
            n_fail++;
            $display("FAIL limit_success: F/E/PC got %b/%b/%0d want 1/0/1", Finished, Error, PC);
        end
        done_lat = 15;
        rb = run_cnt;
        pulse_start(6'd1, 1'b0);
        wait_terminal(100, ok);
        n_cmp++;
        if ({Finished, Error, PC} !== {2'b01, 6'd0}) begin
            n_fail++;
            $display("FAIL limit_late: F/E/PC got %b/%b/%0d want 0/1/0", Finished, Error, PC);
        end
        n_cmp++;
        if (err_rise - run_cyc[rb] !== 15) begin
            n_fail++;
            $display("FAIL limit_late_latency: got %0d want 15", err_rise - run_cyc[rb]);
        end
    endtask

    task automatic test_stop();
        int rb, mb;
        bit ok;
        load_basic();
        done_lat = 3;
        rb = run_cnt;
        mb = memen_cnt;
        pulse_start(6'd4, 1'b0);
        wait_runs(rb + 1, 50, ok);
        n_cmp++;
        if (!ok) begin n_fail++; $display("FAIL stop_first_run: no Run within budget"); end
        Stop = 1'b1;
        @(negedge Clock);
        Stop = 1'b0;
        wait_terminal(100, ok);
        n_cmp++;
        if ({Finished, Halted, Error, Busy} !== 4'b0100) begin
            n_fail++;
            $display("FAIL stop_flags: F/H/E/B got %b want 0100", {Finished, Halted, Error, Busy});
        end
        n_cmp++;
        if (PC !== 6'd1) begin n_fail++; $display("FAIL stop_pc: got %0d want 1", PC); end
        n_cmp++;
        if (memen_cnt - mb !== 1 || run_cnt - rb !== 1) begin
            n_fail++;
            $display("FAIL stop_activity: fetches %0d runs %0d want 1 1", memen_cnt - mb, run_cnt - rb);
        end
    endtask

    task automatic test_zero_len();
        int rb, mb;
        rb = run_cnt;
        mb = memen_cnt;
        pulse_start(6'd0, 1'b0);
        n_cmp++;
        if ({Finished, Halted, Busy} !== 3'b100) begin
            n_fail++;
            $display("FAIL zero_flags: F/H/B got %b want 100", {Finished, Halted, Busy});
        end
        repeat (3) @(negedge Clock);
        n_cmp++;
        if (memen_cnt - mb !== 0 || run_cnt - rb !== 0) begin
            n_fail++;
            $display("FAIL zero_activity: fetches %0d runs %0d want 0 0", memen_cnt - mb, run_cnt - rb);
        end
        n_cmp++;
        if (PC !== 6'd0) begin n_fail++; $display("FAIL zero_pc: got %0d want 0", PC); end
    endtask

    task automatic test_full_len();
        int rb, mb;
        bit ok;
        for (int i = 0; i < 32; i++) mem[i] = 16'(i);
        done_lat = 1;
        rb = run_cnt;
        mb = memen_cnt;
        pulse_start(6'd32, 1'b0);
        wait_terminal(600, ok);
        n_cmp++;
        if (!ok) begin n_fail++; $display("FAIL full_terminal: no terminal state within budget"); end
        n_cmp++;
        if (run_cnt - rb !== 32 || memen_cnt - mb !== 32) begin
            n_fail++;
            $display("FAIL full_activity: runs %0d fetches %0d want 32 32", run_cnt - rb, memen_cnt - mb);
        end
        n_cmp++;
        if (PC !== 6'd32) begin n_fail++; $display("FAIL full_pc: got %0d want 32", PC); end
        n_cmp++;
        if (last_addr !== 5'd31) begin n_fail++; $display("FAIL full_last_addr: got %0d want 31", last_addr); end
        n_cmp++;
        if (run_din[rb+31] !== 16'd31 || Finished !== 1'b1) begin
            n_fail++;
            $display("FAIL full_last_word: DIN %h Finished %b want 001f 1", run_din[rb+31], Finished);
        end
    endtask

    task automatic test_start_stop();
        int rb;
        bit ok;
        done_lat = 1;
        rb = run_cnt;
        pulse_start(6'd2, 1'b1);
        wait_terminal(100, ok);
        n_cmp++;
        if ({Finished, Halted, PC} !== {2'b10, 6'd2}) begin
            n_fail++;
            $display("FAIL start_stop: F/H/PC got %b/%b/%0d want 1/0/2", Finished, Halted, PC);
        end
        n_cmp++;
        if (run_cnt - rb !== 2) begin n_fail++; $display("FAIL start_stop_runs: got %0d want 2", run_cnt - rb); end
    endtask

    task automatic test_reset_mid();
        int rb;
        bit ok;
        logic [32:0] snap;
        load_basic();
        done_lat = 2;
        rb = run_cnt;
        pulse_start(6'd4, 1'b0);
        wait_runs(rb + 2, 100, ok);
        n_cmp++;
        if (PC !== 6'd1 || Busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_pre_reset: PC %0d Busy %b want 1 1", PC, Busy);
        end
        Resetn = 1'b0;
        #1;
        snap = {PC, DIN, Run, MemEn, MemAddr, Busy, Finished, Halted, Error};
        n_cmp++;
        if (snap !== 33'd0) begin
            n_fail++;
            $display("FAIL mid_async_reset: got %h want 0", snap);
        end
        @(negedge Clock);
        Resetn = 1'b1;
        @(negedge Clock);
        rb = run_cnt;
        pulse_start(6'd2, 1'b0);
        wait_terminal(100, ok);
        n_cmp++;
        if ({Finished, PC} !== {1'b1, 6'd2} || run_cnt - rb !== 2) begin
            n_fail++;
            $display("FAIL mid_rerun: F %b PC %0d runs %0d want 1 2 2", Finished, PC, run_cnt - rb);
        end
        n_cmp++;
        if (run_din[rb] !== mem[0]) begin
            n_fail++;
            $display("FAIL mid_rerun_first: got %h want %h", run_din[rb], mem[0]);
        end
    endtask

    initial begin
        Resetn  = 1'b0;
        Start   = 1'b0;
        Stop    = 1'b0;
        ProgLen = 6'd0;
        for (int i = 0; i < 32; i++) mem[i] = 16'd0;
        @(negedge Clock);
        test_reset();
        test_basic();
        test_halt_op();
        test_timeout();
        test_done_at_limit();
        test_stop();
        test_zero_len();
        test_full_len();
        test_start_stop();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
